// File: rtl/cache_lru_history_store.sv
// cache_lru_history_store: per-set pseudo-matrix LRU history RAM with combinational decode/update
module cache_lru_history_store #(
  parameter int NUMWAYS = 2,
  parameter int SET_WIDTH = 9,
  parameter int ENABLE_BYPASS = 1,
  parameter int HIST_W = NUMWAYS*(NUMWAYS-1)/2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [SET_WIDTH-1:0] raddr_i,
  input  logic                 re_i,
  input  logic [SET_WIDTH-1:0] waddr_i,
  input  logic                 we_i,
  input  logic                 wclr_i,
  input  logic [NUMWAYS-1:0]   access_i,
  output logic [HIST_W-1:0]    history_o,
  output logic [HIST_W-1:0]    update_o,
  output logic [NUMWAYS-1:0]   lru_pre_o,
  output logic [NUMWAYS-1:0]   lru_post_o
);
  logic [HIST_W-1:0] mem [2**SET_WIDTH] = '{default: '0};
  logic [HIST_W-1:0] wdata;
  function automatic int off(input int i, input int j);
    return i*(NUMWAYS-1) - i*(i-1)/2 + j - i - 1;
  endfunction
  function automatic logic [NUMWAYS-1:0] decode(input logic [HIST_W-1:0] h);
    logic [NUMWAYS-1:0] l;
    l = '1;
    for (int i = 0; i < NUMWAYS; i++)
      for (int j = 0; j < NUMWAYS; j++)
        if (j < i) l[i] = l[i] & ~h[off(j, i)];
        else if (j > i) l[i] = l[i] & h[off(i, j)];
    return l;
  endfunction
  // Ascending way order, so the highest accessed way ends up MRU.
  function automatic logic [HIST_W-1:0] apply(input logic [HIST_W-1:0] h, input logic [NUMWAYS-1:0] acc);
    logic [HIST_W-1:0] u;
    u = h;
    for (int i = 0; i < NUMWAYS; i++)
      for (int j = i + 1; j < NUMWAYS; j++)
        for (int a = 0; a < NUMWAYS; a++)
          if (acc[a] && a == i) u[off(i, j)] = 1'b0;
          else if (acc[a] && a == j) u[off(i, j)] = 1'b1;
    return u;
  endfunction
  assign update_o = apply(history_o, access_i);
  assign lru_pre_o = decode(history_o);
  assign lru_post_o = decode(update_o);
  assign wdata = wclr_i ? '0 : update_o;
  always_ff @(posedge clk)
    if (we_i && !rst) mem[waddr_i] <= wdata;
  always_ff @(posedge clk)
    if (rst) history_o <= '0;
    else if (re_i) history_o <= (ENABLE_BYPASS != 0 && we_i && waddr_i == raddr_i) ? wdata : mem[raddr_i];
endmodule

// File: tb/tb_cache_lru_history_store.sv
// tb_cache_lru_history_store: directed checks of 4-way (bypass/no-bypass) and 2-way instances
module tb_cache_lru_history_store;
  logic clk = 0, rst = 0;
  always #5 clk = ~clk;
  int checks = 0, failures = 0;
  logic [8:0] a_ra, a_wa, c_ra, c_wa, b_ra, b_wa;
  logic a_re, a_we, a_wc, c_re, c_we, c_wc, b_re, b_we, b_wc;
  logic [3:0] a_acc, a_pre, a_post, c_acc, c_pre, c_post;
  logic [5:0] a_h, a_u, c_h, c_u;
  logic [1:0] b_acc, b_pre, b_post;
  logic [0:0] b_h, b_u;
  cache_lru_history_store #(.NUMWAYS(4), .ENABLE_BYPASS(1)) u_a (
    .clk(clk), .rst(rst), .raddr_i(a_ra), .re_i(a_re), .waddr_i(a_wa), .we_i(a_we), .wclr_i(a_wc),
    .access_i(a_acc), .history_o(a_h), .update_o(a_u), .lru_pre_o(a_pre), .lru_post_o(a_post));
  cache_lru_history_store #(.NUMWAYS(4), .ENABLE_BYPASS(0)) u_c (
    .clk(clk), .rst(rst), .raddr_i(c_ra), .re_i(c_re), .waddr_i(c_wa), .we_i(c_we), .wclr_i(c_wc),
    .access_i(c_acc), .history_o(c_h), .update_o(c_u), .lru_pre_o(c_pre), .lru_post_o(c_post));
  cache_lru_history_store #(.NUMWAYS(2)) u_b (
    .clk(clk), .rst(rst), .raddr_i(b_ra), .re_i(b_re), .waddr_i(b_wa), .we_i(b_we), .wclr_i(b_wc),
    .access_i(b_acc), .history_o(b_h), .update_o(b_u), .lru_pre_o(b_pre), .lru_post_o(b_post));
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  initial begin
    {a_re, a_we, a_wc, c_re, c_we, c_wc, b_re, b_we, b_wc} = '0;
    {a_ra, a_wa, c_ra, c_wa, b_ra, b_wa} = '0;
    a_acc = 0; c_acc = 0; b_acc = 0;
    rst = 1;
    tick();
    rst = 0;
    chk("rst_hist", a_h, 8'h00);
    chk("rst_pre", a_pre, 8'b1000);
    chk("rst_upd", a_u, 8'h00);
    chk("rst_post", a_post, 8'b1000);
    chk("rst_b_pre", b_pre, 8'b10);
    a_acc = 4'b1000;
    #1;
    chk("acc3_upd", a_u, 8'b110100);
    chk("acc3_post", a_post, 8'b0100);
    // same-address read+write on set 5, both bypass modes
    a_re = 1; a_we = 1; a_ra = 5; a_wa = 5;
    c_re = 1; c_we = 1; c_ra = 5; c_wa = 5; c_acc = 4'b1000;
    tick();
    chk("byp_hist", a_h, 8'b110100);
    chk("nobyp_hist", c_h, 8'h00);
    a_we = 0; a_re = 0; a_acc = 0; c_we = 0; c_acc = 0;
    tick();
    chk("hold_hist", a_h, 8'b110100);
    chk("nobyp_reread", c_h, 8'b110100);
    c_re = 0;
    // accesses 0,1,2,3 on set 3 with write-back every cycle
    a_re = 1; a_ra = 3;
    tick();
    chk("seq_start", a_h, 8'h00);
    a_we = 1; a_wa = 3;
    a_acc = 4'b0001; tick(); chk("seq_a0", a_h, 8'b000000);
    a_acc = 4'b0010; tick(); chk("seq_a1", a_h, 8'b000001);
    a_acc = 4'b0100; tick(); chk("seq_a2", a_h, 8'b001011);
    a_acc = 4'b1000; tick(); chk("seq_a3", a_h, 8'b111111);
    a_acc = 0; a_we = 0;
    chk("seq_pre", a_pre, 8'b0001);
    // clear set 3 then read it back
    a_re = 0; a_we = 1; a_wc = 1; a_wa = 3;
    tick();
    a_we = 0; a_wc = 0; a_re = 1; a_ra = 3;
    tick();
    chk("wclr_hist", a_h, 8'h00);
    // 2-way: write history 1 to set 0, read back
    b_we = 1; b_wa = 0; b_acc = 2'b10;
    tick();
    b_we = 0; b_acc = 0; b_re = 1; b_ra = 0;
    tick();
    chk("b_hist", b_h, 8'h01);
    chk("b_pre", b_pre, 8'b01);
    b_acc = 2'b01;
    #1;
    chk("b_upd", b_u, 8'h00);
    chk("b_post", b_post, 8'b10);
    b_acc = 0; b_re = 0;
    // set 7 = 110100, then a reset cycle tries to clear it
    a_re = 0; a_we = 1; a_wa = 7; a_acc = 4'b1000;
    tick();
    a_acc = 0; a_wc = 1;
    rst = 1;
    tick();
    rst = 0; a_we = 0; a_wc = 0;
    chk("rstw_hist", a_h, 8'h00);
    a_re = 1; a_ra = 7;
    tick();
    chk("rstw_keep", a_h, 8'b110100);
    a_re = 0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
